// File: rtl/spi_reg_bank.sv
// SPI control register bank: shadow/active pairs with atomic transfer, readback, status and self-clearing bits.
// Shadow writes land on the strobe edge; active load, readback, xfer_done and addr_err appear one edge later.
module spi_reg_bank #(
  parameter int                         DATA_W    = 8,
  parameter int                         ADDR_W    = 4,
  parameter int                         NUM_REGS  = 8,
  parameter logic [NUM_REGS*DATA_W-1:0] RESET_VAL = {NUM_REGS*DATA_W{1'b0}},
  parameter logic [NUM_REGS*DATA_W-1:0] SC_MASK   = {NUM_REGS*DATA_W{1'b0}}
) (
  input  logic                         sclk,
  input  logic                         rst_n,
  input  logic [ADDR_W-1:0]            Addr,
  input  logic                         WrStb,
  input  logic [DATA_W-1:0]            WrData,
  input  logic                         RdStb,
  output logic [DATA_W-1:0]            RdData,
  output logic                         RdValid,
  input  logic [DATA_W-1:0]            status_in,
  output logic [NUM_REGS*DATA_W-1:0]   cntrl_bits,
  output logic                         xfer_done,
  output logic                         addr_err
);

  localparam int                TOT_W     = NUM_REGS * DATA_W;
  localparam logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(NUM_REGS);
  localparam logic [ADDR_W-1:0] XFER_ADDR = {ADDR_W{1'b1}};

  logic [TOT_W-1:0]  shadow_q, shadow_d;
  logic [TOT_W-1:0]  active_q, active_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q;
  logic              xfer_done_q, xfer_done_d;
  logic              addr_err_q, addr_err_d;
  logic              addr_is_stat, addr_is_xfer, addr_bad;

  always_comb begin
    addr_is_stat = (Addr == STAT_ADDR);
    addr_is_xfer = (Addr == XFER_ADDR);
    addr_bad     = (Addr > STAT_ADDR) && !addr_is_xfer;

    shadow_d  = shadow_q;
    rd_data_d = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (Addr == ADDR_W'(k)) begin
        if (WrStb) shadow_d[k*DATA_W +: DATA_W] = WrData;
        // Readback takes the pre-write shadow, so a same-cycle write is not visible.
        rd_data_d = shadow_q[k*DATA_W +: DATA_W];
      end
    end
    if (addr_is_stat) rd_data_d = status_in;

    xfer_done_d = WrStb && addr_is_xfer && WrData[0];
    // A reload overrides the self-clear of pulse bits.
    active_d    = xfer_done_d ? shadow_q : (active_q & ~SC_MASK);
    addr_err_d  = (WrStb && (addr_is_stat || addr_bad)) || (RdStb && addr_bad);
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q    <= RESET_VAL;
      active_q    <= RESET_VAL;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      xfer_done_q <= 1'b0;
      addr_err_q  <= 1'b0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      xfer_done_q <= xfer_done_d;
      addr_err_q  <= addr_err_d;
      if (RdStb) begin
        rd_data_q  <= rd_data_d;
        rd_valid_q <= 1'b1;
      end
    end
  end

  assign RdData     = rd_data_q;
  assign RdValid    = rd_valid_q;
  assign cntrl_bits = active_q;
  assign xfer_done  = xfer_done_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Bench for spi_reg_bank: directed scenarios plus random traffic against an array-based register model.
module tb_spi_reg_bank;

  localparam logic [63:0] RV = 64'h00000000_000000A5;
  localparam logic [63:0] SC = 64'h00000000_00000100;

  logic        sclk = 1'b0;
  logic        rst_n;
  logic [3:0]  Addr;
  logic        WrStb;
  logic [7:0]  WrData;
  logic        RdStb;
  logic [7:0]  RdData;
  logic        RdValid;
  logic [7:0]  status_in;
  logic [63:0] cntrl_bits;
  logic        xfer_done;
  logic        addr_err;

  spi_reg_bank #(
    .DATA_W(8), .ADDR_W(4), .NUM_REGS(8), .RESET_VAL(RV), .SC_MASK(SC)
  ) dut (
    .sclk(sclk), .rst_n(rst_n), .Addr(Addr), .WrStb(WrStb), .WrData(WrData),
    .RdStb(RdStb), .RdData(RdData), .RdValid(RdValid), .status_in(status_in),
    .cntrl_bits(cntrl_bits), .xfer_done(xfer_done), .addr_err(addr_err)
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] m_shadow [8];
  logic [7:0] m_active [8];
  logic [7:0] m_rd;
  logic       m_rv, m_xd, m_ae;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [63:0] m_flat();
    logic [63:0] f;
    for (int k = 0; k < 8; k++) f[k*8 +: 8] = m_active[k];
    return f;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 8; k++) begin
      m_shadow[k] = RV[k*8 +: 8];
      m_active[k] = RV[k*8 +: 8];
    end
    m_rd = 8'h00; m_rv = 1'b0; m_xd = 1'b0; m_ae = 1'b0;
  endtask

  // One clock edge worth of register-map behaviour, using the state before the edge.
  task automatic model_step(input logic [3:0] a, input logic w, input logic [7:0] d,
                            input logic r, input logic [7:0] st);
    logic xfer, bad;
    logic [63:0] scm;
    scm  = SC;
    bad  = (a > 4'd8) && (a < 4'd15);
    xfer = w && (a == 4'd15) && d[0];
    if (r) begin
      if (a < 4'd8)       m_rd = m_shadow[a[2:0]];
      else if (a == 4'd8) m_rd = st;
      else                m_rd = 8'h00;
      m_rv = 1'b1;
    end
    for (int k = 0; k < 8; k++)
      m_active[k] = xfer ? m_shadow[k] : (m_active[k] & ~scm[k*8 +: 8]);
    if (w && a < 4'd8) m_shadow[a[2:0]] = d;
    m_xd = xfer;
    m_ae = (w && (a == 4'd8 || bad)) || (r && bad);
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".cntrl"},   cntrl_bits, m_flat());
    check_eq({tag, ".rddata"},  {56'd0, RdData}, {56'd0, m_rd});
    check_eq({tag, ".rdvalid"}, {63'd0, RdValid}, {63'd0, m_rv});
    check_eq({tag, ".xfer"},    {63'd0, xfer_done}, {63'd0, m_xd});
    check_eq({tag, ".aerr"},    {63'd0, addr_err}, {63'd0, m_ae});
  endtask

  // Called at a falling edge; inputs change there, outputs are sampled at the next falling edge.
  task automatic cycle(input string tag, input logic [3:0] a, input logic w, input logic [7:0] d,
                       input logic r, input logic [7:0] st);
    Addr = a; WrStb = w; WrData = d; RdStb = r; status_in = st;
    @(posedge sclk);
    model_step(a, w, d, r, st);
    @(negedge sclk);
    compare_all(tag);
  endtask

  task automatic idle(input string tag);
    cycle(tag, 4'd0, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic async_reset(input string tag);
    Addr = 4'd0; WrStb = 1'b0; WrData = 8'h00; RdStb = 1'b0;
    #2 rst_n = 1'b0;
    model_reset();
    #1 compare_all(tag);
    @(negedge sclk);
    compare_all(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; Addr = 4'd0; WrStb = 1'b0; WrData = 8'h00; RdStb = 1'b0; status_in = 8'h00;
    model_reset();
    repeat (2) @(negedge sclk);
    compare_all("rst");
    check_eq("rst.reg0", {56'd0, cntrl_bits[7:0]}, 64'hA5);
    rst_n = 1'b1;

    // Reset value readback
    cycle("t1.rd0", 4'd0, 1'b0, 8'h00, 1'b1, 8'h00);
    check_eq("t1.rdA5", {56'd0, RdData}, 64'hA5);

    // Shadow write is invisible on cntrl_bits until transfer
    cycle("t2.wr", 4'd2, 1'b1, 8'h3C, 1'b0, 8'h00);
    check_eq("t2.noact", {56'd0, cntrl_bits[23:16]}, 64'h00);
    cycle("t2.rd", 4'd2, 1'b0, 8'h00, 1'b1, 8'h00);
    check_eq("t2.rb", {56'd0, RdData}, 64'h3C);
    cycle("t2.nx", 4'd15, 1'b1, 8'h00, 1'b0, 8'h00);
    cycle("t2.xf", 4'd15, 1'b1, 8'h01, 1'b0, 8'h00);
    check_eq("t2.act", {56'd0, cntrl_bits[23:16]}, 64'h3C);
    check_eq("t2.xd", {63'd0, xfer_done}, 64'd1);
    idle("t2.idle");
    check_eq("t2.xd0", {63'd0, xfer_done}, 64'd0);

    // Multi-register atomic update
    cycle("t3.w0", 4'd0, 1'b1, 8'h11, 1'b0, 8'h00);
    cycle("t3.w1", 4'd1, 1'b1, 8'h22, 1'b0, 8'h00);
    cycle("t3.w2", 4'd2, 1'b1, 8'h33, 1'b0, 8'h00);
    check_eq("t3.pre", {40'd0, cntrl_bits[23:0]}, 64'h3C00A5);
    cycle("t3.xf", 4'd15, 1'b1, 8'hFF, 1'b0, 8'h00);
    check_eq("t3.post", {40'd0, cntrl_bits[23:0]}, 64'h332211);

    // Self-clearing bit 8 pulses, bit 15 holds; second transfer re-pulses
    cycle("t4.w1", 4'd1, 1'b1, 8'h81, 1'b0, 8'h00);
    cycle("t4.xf", 4'd15, 1'b1, 8'h01, 1'b0, 8'h00);
    check_eq("t4.p1", {56'd0, cntrl_bits[15:8]}, 64'h81);
    idle("t4.i1");
    check_eq("t4.c1", {56'd0, cntrl_bits[15:8]}, 64'h80);
    cycle("t4.xf2", 4'd15, 1'b1, 8'h01, 1'b0, 8'h00);
    check_eq("t4.p2", {56'd0, cntrl_bits[15:8]}, 64'h81);
    cycle("t4.xf3", 4'd15, 1'b1, 8'h01, 1'b0, 8'h00);
    check_eq("t4.p3", {56'd0, cntrl_bits[15:8]}, 64'h81);
    idle("t4.i2");

    // Invalid and read-only accesses
    cycle("t5.ws", 4'd8, 1'b1, 8'hFF, 1'b0, 8'h00);
    check_eq("t5.ae1", {63'd0, addr_err}, 64'd1);
    idle("t5.i1");
    cycle("t5.wi", 4'd12, 1'b1, 8'hFF, 1'b0, 8'h00);
    check_eq("t5.ae2", {63'd0, addr_err}, 64'd1);
    cycle("t5.rs", 4'd8, 1'b0, 8'h00, 1'b1, 8'h5A);
    check_eq("t5.st", {56'd0, RdData}, 64'h5A);
    check_eq("t5.ae0", {63'd0, addr_err}, 64'd0);
    cycle("t5.ri", 4'd12, 1'b0, 8'h00, 1'b1, 8'h5A);
    check_eq("t5.r0", {56'd0, RdData}, 64'h00);
    cycle("t5.rx", 4'd15, 1'b0, 8'h00, 1'b1, 8'h5A);
    cycle("t5.rw", 4'd3, 1'b1, 8'h77, 1'b1, 8'h00);
    idle("t5.i2");

    // Reset between shadow write and transfer discards the shadow
    cycle("t6.w", 4'd3, 1'b1, 8'hEE, 1'b0, 8'h00);
    async_reset("t6.rst");
    cycle("t6.xf", 4'd15, 1'b1, 8'h01, 1'b0, 8'h00);
    check_eq("t6.act", cntrl_bits, RV);
    idle("t6.i");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      logic [3:0] a;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 6)       a = 4'($urandom_range(0, 7));
      else if (sel == 6) a = 4'd8;
      else if (sel == 7) a = 4'd15;
      else if (sel == 8) a = 4'($urandom_range(9, 14));
      else               a = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 149) == 0) async_reset("rnd.rst");
      cycle("rnd", a, 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

endmodule
